// File: rtl/spi_master_p.sv
// -----------------------------------------------------------------------------
// spi_master_p -- parametrised SPI master (CPOL/CPHA at runtime, N chip selects)
//
// Purpose:
//   Shifts one DATA_W-bit word out on MOSI while shifting one in from MISO.
//   SCK is produced by a divider running on CLK (never gated from CLK).
//   A frame runs through SETUP (1 half-period), XFER (2*DATA_W half-periods,
//   with SCK toggling at the end of each) and HOLD (1 half-period), so BUSY is
//   high for exactly (2*DATA_W+2)*CLK_DIV cycles.
//
// Handshake (START/BUSY/DONE):
//   A request is START=1 at a posedge while the master is idle (BUSY=0); that
//   edge accepts it and latches DOUT, CS_SEL, CPOL, CPHA (and LSB_FIRST).
//   START seen while BUSY=1 is dropped, never queued. DONE pulses for one cycle
//   on the edge that ends the frame; DIN changes only on that edge.
//
// Ports:
//   CLK, RST         system clock, asynchronous active-high reset
//   START            transfer request
//   CS_SEL           chip select index (>= NCS runs the frame with no CS low)
//   CPOL, CPHA       SPI mode for the frame
//   DOUT / DIN       word to send / last word received
//   BUSY, DONE       frame in progress / one-cycle end-of-frame strobe
//   CS               active-low chip selects
//   SCK, MOSI, MISO  SPI serial lines
//   DBG_STATE        current FSM state (0 IDLE, 1 SETUP, 2 XFER, 3 HOLD)
//
// Optional feature (macro SPI_LSB_FIRST_EN):
//   Adds input LSB_FIRST. When 1 the word is sent DOUT[0] first and the first
//   received bit lands in DIN[0]. Without the macro the master is MSB-first.
// -----------------------------------------------------------------------------
module spi_master_p #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int NCS     = 2,
   parameter int SEL_W   = (NCS > 1) ? $clog2(NCS) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [SEL_W-1:0]  CS_SEL,
   input  logic              CPOL,
   input  logic              CPHA,
   input  logic [DATA_W-1:0] DOUT,
`ifdef SPI_LSB_FIRST_EN
   input  logic              LSB_FIRST,
`endif
   output logic [DATA_W-1:0] DIN,
   output logic              BUSY,
   output logic              DONE,
   output logic [NCS-1:0]    CS,
   output logic              SCK,
   input  logic              MISO,
   output logic              MOSI,
   output logic [1:0]        DBG_STATE
);

   localparam int HP_W   = $clog2(CLK_DIV + 1);
   localparam int EDGE_W = $clog2(2 * DATA_W + 1);
   localparam logic [HP_W-1:0]   HP_LAST   = HP_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_XFER  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [HP_W-1:0]     hp_q, hp_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic                sck_q, sck_d;
   logic                mosi_q, mosi_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic [DATA_W-1:0]   din_q, din_d;
   logic [NCS-1:0]      cs_q, cs_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                cpha_q, cpha_d;
   logic                lsb_q, lsb_d;

   logic                lsb_in;
   logic                hp_end;
   logic                leading;
   logic                sample_edge;
   logic [NCS-1:0]      cs_dec;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = LSB_FIRST;
`else
   assign lsb_in = 1'b0;
`endif

   assign hp_end = (hp_q == HP_LAST);

   // Out-of-range CS_SEL simply matches no line, leaving all CS high.
   always_comb begin
      cs_dec = '1;
      for (int i = 0; i < NCS; i++) begin
         if (CS_SEL == SEL_W'(i)) cs_dec[i] = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         hp_q    <= '0;
         edge_q  <= '0;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         din_q   <= '0;
         cs_q    <= '1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         edge_q  <= edge_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         din_q   <= din_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hp_d        = hp_q;
      edge_d      = edge_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      din_d       = din_q;
      cs_d        = cs_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      cpha_d      = cpha_q;
      lsb_d       = lsb_q;
      // edge_q counts completed SCK edges; an even count means the next edge
      // leaves the idle level, i.e. it is a leading edge.
      leading     = ~edge_q[0];
      // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
      sample_edge = leading ^ cpha_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_SETUP;
               hp_d    = '0;
               edge_d  = '0;
               sck_d   = CPOL;
               cpha_d  = CPHA;
               lsb_d   = lsb_in;
               tx_d    = DOUT;
               rx_d    = '0;
               mosi_d  = lsb_in ? DOUT[0] : DOUT[DATA_W-1];
               cs_d    = cs_dec;
               busy_d  = 1'b1;
            end
         end
         S_SETUP: begin
            if (hp_end) begin
               state_d = S_XFER;
               hp_d    = '0;
            end else begin
               hp_d = hp_q + HP_W'(1);
            end
         end
         S_XFER: begin
            if (hp_end) begin
               hp_d   = '0;
               edge_d = edge_q + EDGE_W'(1);
               sck_d  = ~sck_q;
               if (sample_edge) begin
                  rx_d = lsb_q ? {MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], MISO};
               end else if (cpha_q ? (edge_q != '0) : (edge_q != EDGE_LAST)) begin
                  // CPHA=1: the first leading edge keeps the first bit already
                  // on MOSI. CPHA=0: nothing left to shift after the last edge.
                  tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                  mosi_d = lsb_q ? tx_q[1] : tx_q[DATA_W-2];
               end
               if (edge_q == EDGE_LAST) state_d = S_HOLD;
            end else begin
               hp_d = hp_q + HP_W'(1);
            end
         end
         S_HOLD: begin
            if (hp_end) begin
               state_d = S_IDLE;
               hp_d    = '0;
               busy_d  = 1'b0;
               cs_d    = '1;
               mosi_d  = 1'b0;
               din_d   = rx_q;
               done_d  = 1'b1;
            end else begin
               hp_d = hp_q + HP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign DIN       = din_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign CS        = cs_q;
   assign SCK       = sck_q;
   assign MOSI      = mosi_q;
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_spi_master_p.sv
// -----------------------------------------------------------------------------
// tb_spi_master_p -- self-checking bench for spi_master_p
// (DATA_W=8, CLK_DIV=2, NCS=2, SEL_W=2 so that CS_SEL=3 is representable).
// A negedge monitor acts as an SPI slave: it returns a chosen word on MISO in
// the frame's bit order and rebuilds the word seen on MOSI from the SPI mode
// rules alone. The driver task compares frame-level facts (cycle counts, edge
// counts, CS levels, received words) against values derived from the mode.
// -----------------------------------------------------------------------------
module tb_spi_master_p;

   localparam int DATA_W    = 8;
   localparam int CLK_DIV   = 2;
   localparam int NCS       = 2;
   localparam int SEL_W     = 2;
   localparam int FRAME_CYC = (2 * DATA_W + 2) * CLK_DIV;

   // ---------------- clock / reset ----------------
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic              START = 1'b0;
   logic [SEL_W-1:0]  CS_SEL = '0;
   logic              CPOL = 1'b0;
   logic              CPHA = 1'b0;
   logic [DATA_W-1:0] DOUT = '0;
   logic [DATA_W-1:0] DIN;
   logic              BUSY;
   logic              DONE;
   logic [NCS-1:0]    CS;
   logic              SCK;
   logic              MISO;
   logic              MOSI;
   logic [1:0]        dbg_state;

   // frame context used by the slave model
   logic              cur_lsb = 1'b0;
   logic              cur_cpol = 1'b0;
   logic              cur_cpha = 1'b0;
   logic              loopback = 1'b1;
   logic              slave_miso = 1'b0;
   logic [DATA_W-1:0] slave_word = '0;
   logic [DATA_W-1:0] slave_rx = '0;
   logic [NCS-1:0]    exp_cs = '1;

   int tests_run = 0;
   int tests_failed = 0;
   logic [DATA_W-1:0] exp_q[$];

   // monitor counters (monotonic; the driver works with differences)
   int mon_busy = 0, mon_edges = 0, mon_rises = 0, mon_cs_bad = 0;
   int mon_mosi_bad = 0, mon_frames = 0, mon_done = 0;
   int cs_run = 0, last_gap = 0;
   int kt = 0, kr = 0;
   logic sck_p = 1'b0, mosi_p = 1'b0, busy_p = 1'b0;

   assign MISO = loopback ? MOSI : slave_miso;

   spi_master_p #(
      .DATA_W (DATA_W),
      .CLK_DIV(CLK_DIV),
      .NCS    (NCS),
      .SEL_W  (SEL_W)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .START    (START),
      .CS_SEL   (CS_SEL),
      .CPOL     (CPOL),
      .CPHA     (CPHA),
      .DOUT     (DOUT),
`ifdef SPI_LSB_FIRST_EN
      .LSB_FIRST(cur_lsb),
`endif
      .DIN      (DIN),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .CS       (CS),
      .SCK      (SCK),
      .MISO     (MISO),
      .MOSI     (MOSI),
      .DBG_STATE(dbg_state)
   );

   // k-th bit on the wire maps to this word position
   function automatic int bpos(input int k);
      return cur_lsb ? k : (DATA_W - 1 - k);
   endfunction

   // ---------------- slave model / monitor ----------------
   always @(negedge CLK) begin
      logic edge_seen;
      logic samp;
      edge_seen = 1'b0;
      samp      = 1'b0;
      if (BUSY) mon_busy++;
      if (DONE) mon_done++;
      if (BUSY ? (CS != exp_cs) : (CS != '1)) mon_cs_bad++;
      if (CS == '1) cs_run++;
      else begin
         if (cs_run > 0) last_gap = cs_run;
         cs_run = 0;
      end
      if (BUSY && !busy_p) begin
         mon_frames++;
         slave_rx = '0;
         kt = 0;
         kr = 0;
         if (!cur_cpha) begin
            slave_miso = slave_word[bpos(0)];
            kt = 1;
         end
      end else if (BUSY && (SCK != sck_p)) begin
         edge_seen = 1'b1;
         mon_edges++;
         if (SCK) mon_rises++;
         // leading edge leaves the idle level; CPHA picks which edge samples
         samp = ((sck_p == cur_cpol) != cur_cpha);
         if (samp) begin
            if (kr < DATA_W) slave_rx[bpos(kr)] = MOSI;
            kr++;
         end else begin
            if (kt < DATA_W) slave_miso = slave_word[bpos(kt)];
            kt++;
         end
      end
      if (BUSY && busy_p && (MOSI != mosi_p) && !(edge_seen && !samp)) mon_mosi_bad++;
      sck_p  = SCK;
      mosi_p = MOSI;
      busy_p = BUSY;
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Drives one request from between clock edges. keep_start leaves START high
   // so the next call is accepted straight after this frame's DONE.
   task automatic do_frame(input logic [DATA_W-1:0] dout, input logic [SEL_W-1:0] sel,
                           input logic cpol, input logic cpha, input logic loop,
                           input logic [DATA_W-1:0] sw, input logic keep_start);
      int b0, e0, r0, c0, m0, f0, d0;
      logic seen;
      logic [DATA_W-1:0] exp_din;
      cur_cpol   = cpol;
      cur_cpha   = cpha;
      loopback   = loop;
      slave_word = sw;
      exp_cs     = '1;
      if (int'(sel) < NCS) exp_cs[sel] = 1'b0;
      exp_din = loop ? dout : sw;
      exp_q.push_back(exp_din);
      b0 = mon_busy; e0 = mon_edges; r0 = mon_rises; c0 = mon_cs_bad;
      m0 = mon_mosi_bad; f0 = mon_frames; d0 = mon_done;
      DOUT = dout; CS_SEL = sel; CPOL = cpol; CPHA = cpha; START = 1'b1;
      @(posedge CLK); #1;
      if (!keep_start) START = 1'b0;
      check("accept_busy", BUSY, 1);
      check("accept_cs", CS, exp_cs);
      check("accept_sck", SCK, cpol);
      seen = 1'b0;
      for (int t = 0; t < 4 * FRAME_CYC && !seen; t++) begin
         @(negedge CLK); #1;
         seen = DONE;
      end
      check("done_seen", seen, 1);
      check("busy_cycles", mon_busy - b0, FRAME_CYC);
      check("sck_edges", mon_edges - e0, 2 * DATA_W);
      check("sck_rises", mon_rises - r0, DATA_W);
      check("frame_count", mon_frames - f0, 1);
      check("done_count", mon_done - d0, 1);
      check("cs_levels", mon_cs_bad - c0, 0);
      check("mosi_timing", mon_mosi_bad - m0, 0);
      check("slave_rx", slave_rx, dout);
      check("din", DIN, exp_q.pop_front());
      check("sck_idle", SCK, cpol);
      if (!keep_start) begin
         @(negedge CLK); #1;
         check("done_pulse", DONE, 0);
         check("din_hold", DIN, exp_din);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      // reset values
      repeat (2) @(posedge CLK);
      #1;
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_din", DIN, 0);
      check("rst_cs", CS, 2'b11);
      check("rst_sck", SCK, 0);
      check("rst_mosi", MOSI, 0);
      RST = 1'b0;
      @(posedge CLK); #1;
      check("idle_busy", BUSY, 0);

      // mode 0 loopback, CS_SEL=1
      do_frame(8'hA5, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      // mode 3 against slave returning 0xC3
      do_frame(8'h3C, 2'd0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0);
      // idle CPOL change must not move SCK
      CPOL = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("idle_cpol_hold", SCK, 1);

      // START held through a frame, next frame accepted right after DONE
      do_frame(8'h96, 2'd0, 1'b0, 1'b0, 1'b0, 8'h5B, 1'b1);
      do_frame(8'h4E, 2'd0, 1'b0, 1'b0, 1'b0, 8'hE1, 1'b0);
      check("cs_gap", last_gap, 1);

      // invalid chip select
      do_frame(8'hFF, 2'd3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

`ifdef SPI_LSB_FIRST_EN
      cur_lsb = 1'b1;
      do_frame(8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      do_frame(8'h2D, 2'd1, 1'b1, 1'b1, 1'b0, 8'hB4, 1'b0);
      cur_lsb = 1'b0;
`endif

      // randomized frames
      for (int n = 0; n < 10; n++) begin
`ifdef SPI_LSB_FIRST_EN
         cur_lsb = 1'($urandom_range(0, 1));
`endif
         do_frame(DATA_W'($urandom), SEL_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom), 1'b0);
      end
      cur_lsb = 1'b0;

      // reset in the middle of a mode-2 frame
      cur_cpol = 1'b1; cur_cpha = 1'b0; loopback = 1'b1; exp_cs = 2'b10;
      DOUT = 8'h5A; CS_SEL = 2'd0; CPOL = 1'b1; CPHA = 1'b0; START = 1'b1;
      d0 = mon_done;
      @(posedge CLK); #1;
      START = 1'b0;
      check("mid_busy", BUSY, 1);
      repeat (9) @(posedge CLK);
      #1 RST = 1'b1;
      #1;
      check("abort_cs", CS, 2'b11);
      check("abort_sck", SCK, 0);
      check("abort_busy", BUSY, 0);
      check("abort_din", DIN, 0);
      check("abort_mosi", MOSI, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (2 * FRAME_CYC) @(posedge CLK);
      #1;
      check("abort_no_done", mon_done - d0, 0);
      check("abort_din_after", DIN, 0);
      check("abort_idle", BUSY, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
